// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and default widths for the instruction fetch unit
package ifetch_pkg;

    localparam int IF_ADDR_W = 2;
    localparam int IF_DATA_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry queue of {pc, data} words with flush
module fetch_fifo #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic         wr_q, rd_q;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    assign empty   = cnt_q == 2'd0;
    assign full    = cnt_q == 2'd2;
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};

    // Storage and pointers; flush drops every queued entry at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush) begin
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= ~wr_q;
            end
            if (do_pop) rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC/FSM front end feeding a 2-entry fetch queue; IFETCH_WRAP_EN wraps PC at end of memory
import ifetch_pkg::*;

module instr_fetch #(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int DATA_W = IF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy,
    output logic              done
);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic                     push, pop, full, empty;
    logic [1:0]               count;
    logic [ADDR_W+DATA_W-1:0] head;

    // Redirect owns the cycle: no pop, no push, queue flushed
    assign pop       = !empty && out_ready && !redirect_valid;
    assign push      = (state_q == FETCH) && !redirect_valid && !stop && (!full || pop);
    assign mem_addr  = pc_q;
    assign out_valid = !empty;
    assign out_pc    = head[ADDR_W+DATA_W-1:DATA_W];
    assign out_data  = head[DATA_W-1:0];
    assign busy      = state_q == FETCH;
    assign done      = state_q == DONE;

    fetch_fifo #(.W(ADDR_W + DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({pc_q, mem_data}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Next state and PC: redirect first, then start/stop/advance
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = FETCH;
            pc_d    = redirect_addr;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
                FETCH: if (stop) begin
                    state_d = IDLE;
                end else if (push) begin
`ifdef IFETCH_WRAP_EN
                    pc_d = pc_q + ADDR_W'(1);
`else
                    if (&pc_q) state_d = DONE;
                    else       pc_d    = pc_q + ADDR_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    // State and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // The queue's full flag and occupancy must always agree
    a_full_count: assert property (@(posedge clk) disable iff (rst) full == (count == 2'd2));

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch latency, backpressure, redirect, end of memory, reset and stop
import ifetch_pkg::*;

module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [1:0] redirect_addr = 2'd0;
    logic [1:0] mem_addr;
    logic [1:0] mem_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_data;
    logic [1:0] out_pc;
    logic       busy;
    logic       done;
    logic [7:0] rom = 8'b00_11_10_01;
    int         n_tests = 0;
    int         n_fail = 0;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_pc         (out_pc),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always_comb mem_data = rom[{mem_addr, 1'b0} +: 2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [1:0] pc, input logic [1:0] data);
        entry_t e;
        e.pc   = pc;
        e.data = data;
        check(tag, 32'({out_valid, out_pc, out_data}), 32'({1'b1, e}));
    endtask

    task automatic do_reset(input string tag);
        #1;
        rst = 1'b1;
        #1;
        check(tag, 32'({out_valid, out_data, out_pc, mem_addr, busy, done}), 32'd0);
        step();
        start          = 1'b0;
        stop           = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        rst            = 1'b0;
    endtask

    initial begin
        // Streaming from start with the consumer always ready
        do_reset("reset_initial");
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'({busy, out_valid, mem_addr}), 32'({1'b1, 1'b0, 2'd0}));
        step();
        expect_head("stream0", 2'd0, 2'b01);
        step();
        expect_head("stream1", 2'd1, 2'b10);
        step();
        expect_head("stream2", 2'd2, 2'b11);
        step();
        expect_head("stream3", 2'd3, 2'b00);
`ifdef IFETCH_WRAP_EN
        step();
        expect_head("wrap0", 2'd0, 2'b01);
        step();
        expect_head("wrap1", 2'd1, 2'b10);
`else
        check("done_after_last", 32'(done), 32'd1);
        step();
        check("drained_after_four", 32'({out_valid, done, busy}), 32'({1'b0, 1'b1, 1'b0}));
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored_done", 32'({done, out_valid}), 32'({1'b1, 1'b0}));
`endif
        redirect_valid = 1'b1;
        redirect_addr  = 2'd2;
        step();
        redirect_valid = 1'b0;
        check("redirect_exit", 32'({busy, done, out_valid, mem_addr}), 32'({1'b1, 1'b0, 1'b0, 2'd2}));
        step();
        expect_head("redirect_first", 2'd2, 2'b11);

        // Backpressure: queue fills, PC holds, start is ignored in FETCH
        do_reset("reset_bp");
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            step();
            start = 1'b0;
            expect_head("bp_hold_head", 2'd0, 2'b01);
        end
        check("bp_mem_addr", 32'(mem_addr), 32'd2);
        out_ready = 1'b1;
        step();
        expect_head("bp_release1", 2'd1, 2'b10);
        step();
        expect_head("bp_release2", 2'd2, 2'b11);

        // Redirect with a full queue discards queued words
        do_reset("reset_redir");
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("redir_full_addr", 32'(mem_addr), 32'd2);
        redirect_valid = 1'b1;
        redirect_addr  = 2'd3;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("redir_flush", 32'({out_valid, mem_addr, busy}), 32'({1'b0, 2'd3, 1'b1}));
        step();
        expect_head("redir_target", 2'd3, 2'b00);
        step();
`ifdef IFETCH_WRAP_EN
        expect_head("redir_wrap", 2'd0, 2'b01);
`else
        check("redir_end", 32'({out_valid, done}), 32'({1'b0, 1'b1}));
`endif

        // Reset mid-fetch with a full queue
        do_reset("reset_pre_mid");
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        expect_head("mid_full", 2'd0, 2'b01);
        do_reset("reset_mid_fetch");
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        expect_head("restart_head", 2'd0, 2'b01);

        // Stop with one word queued
        do_reset("reset_stop");
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_idle", 32'({busy, mem_addr}), 32'({1'b0, 2'd1}));
        expect_head("stop_remaining", 2'd0, 2'b01);
        out_ready = 1'b1;
        step();
        check("stop_drained", 32'(out_valid), 32'd0);
        step();
        check("stop_no_push", 32'({out_valid, mem_addr, busy}), 32'({1'b0, 2'd1, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 2, SHALL be the instruction address width.
REQ-002 Parameter DATA_W, default 2, SHALL be the instruction word width; DEPTH = 2**ADDR_W.
REQ-003 Port list; one clock; reset is asynchronous and active-high:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  IDLE->FETCH request, PC from 0.
- stop  input  1  cease fetching; queued words still drain.
- redirect_valid  input  1  load PC from redirect_addr, flush queue.
- redirect_addr  input  ADDR_W  redirect target.
- mem_addr  output  ADDR_W  read address to instruction memory; equals PC register.
- mem_data  input  DATA_W  combinational read data for mem_addr, valid in the same cycle.
- out_valid  output  1  queue head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  DATA_W  head instruction word.
- out_pc  output  ADDR_W  address of head word.
- busy  output  1  state is FETCH.
- done  output  1  state is DONE.

Function
REQ-004 States SHALL be IDLE, FETCH, DONE; registered state, reset to IDLE.
REQ-005 IDLE: start=1 -> FETCH with PC=0; otherwise hold.
REQ-006 FETCH: push allowed when count<2, or count==2 with out_valid&&out_ready the same cycle; on push, {PC, mem_data} written at queue tail and PC increments by 1.
REQ-007 Queue SHALL be a 2-entry FIFO; pop when out_valid&&out_ready; simultaneous push/pop leaves count unchanged.
REQ-008 Queue full without pop: no push, PC and mem_addr hold.
REQ-009 out_valid SHALL be 1 whenever count>0; out_data/out_pc SHALL hold the head entry and remain stable while out_valid&&!out_ready.
REQ-010 Latency: start sampled at edge N -> first push at edge N+1 -> out_valid=1 after edge N+1; sustained throughput 1 word/cycle with out_ready=1.
REQ-011 redirect_valid SHALL have highest priority in every state: queue flushed (count=0), PC=redirect_addr, state->FETCH, no push or pop that cycle.
REQ-012 stop=1 (no redirect) in FETCH: state->IDLE, no push that cycle; queue contents remain and drain normally.
REQ-013 start in FETCH or DONE SHALL be ignored.
REQ-014 End of memory: push at PC=DEPTH-1 handled per REQ-017; PC arithmetic is modulo DEPTH.
REQ-015 When count==0 and out_ready=1, no pop occurs and nothing changes.

Reset
REQ-016 rst=1 SHALL immediately force state=IDLE, PC=0, count=0, queue contents=0, mem_addr=0, out_valid=0, out_data=0, out_pc=0, busy=0, done=0; reset mid-fetch discards all queued words.

Configuration
REQ-017 Macro IFETCH_WRAP_EN: defined -> push at PC=DEPTH-1 wraps PC to 0 and FETCH continues; undefined -> push at PC=DEPTH-1 leaves PC at DEPTH-1, state->DONE, no further pushes; DONE exits only via redirect_valid or rst.

Structure
REQ-018 Package ifetch_pkg SHALL hold the state enum (IDLE, FETCH, DONE), default ADDR_W/DATA_W constants and the queue-entry typedef {pc, data}.
REQ-019 Sub-module fetch_fifo SHALL implement the 2-entry queue with push/pop/count/full/empty; instr_fetch holds PC and FSM.

Verification
REQ-020 Memory model {01,10,11,00}; reset, start pulse, out_ready=1 -> out_data 01,10,11,00 with out_pc 0,1,2,3 on consecutive cycles from second edge after start.
REQ-021 Same, out_ready=0 for 5 cycles -> count=2, out_data=01 stable, mem_addr=2 held; release -> 01,10 then 11 without gap or duplication.
REQ-022 Redirect to addr 3 while count=2 -> next cycle out_valid=0; then out_pc=3, out_data=00; queued 01/10 never delivered.
REQ-023 IFETCH_WRAP_EN undefined: run to end -> done=1 after PC=3 push, exactly 4 words delivered; defined -> out_pc sequence 0,1,2,3,0,1 continuous.
REQ-024 rst asserted while count=2 mid-FETCH -> all outputs zero immediately, state IDLE; start afterwards restarts at out_pc=0.
REQ-025 stop with count=1 -> busy=0 next cycle, remaining word delivered, no further pushes.
